// File: rtl/z80_bus_cycle_unit.sv
// Z80 machine-cycle sequencer: turns one accepted request into a T-state sequence
// (T1, T2, TW*, T3[, T4]) with registered bus strobes, wait states and M1 refresh.
module z80_bus_cycle_unit #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MEM_WAIT   = 0,
  parameter int IO_WAIT    = 1,
  parameter int REFRESH_EN = 1
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-9:0] rfsh_hi,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_oe,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              WAIT_L,
  output logic              M1_L,
  output logic              MREQ_L,
  output logic              IORQ_L,
  output logic              RD_L,
  output logic              WR_L,
  output logic              RFSH_L,
  output logic [2:0]        dbg_state_o,
  output logic [6:0]        dbg_r_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5
  } state_e;

  localparam logic [2:0] TY_M1   = 3'd0;
  localparam logic [2:0] TY_MRD  = 3'd1;
  localparam logic [2:0] TY_MWR  = 3'd2;
  localparam logic [2:0] TY_IORD = 3'd3;
  localparam logic [2:0] TY_IOWR = 3'd4;

  state_e              state_q, state_d;
  logic [2:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [6:0]          r_q, r_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          auto_n;
  logic                final_st;
  logic                is_read;

  logic                m1_d, mreq_d, iorq_d, rd_d, wr_d, rfsh_d;
  logic                addr_oe_d, data_oe_d, rsp_valid_d;
  logic [ADDR_W-1:0]   addr_out_d;
  logic [DATA_W-1:0]   data_out_d;
  logic                in_t12w, in_acc, in_t23;

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
  // req_ready is a function of the current state only (IDLE or the final T-state).
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;
    r_d      = r_q;
    rdata_d  = rdata_q;
    final_st = (state_q == S_T4) || (state_q == S_T3 && type_q != TY_M1);
    req_ready = (state_q == S_IDLE) || final_st;
    is_read  = (type_q == TY_M1) || (type_q == TY_MRD) || (type_q == TY_IORD);
    if (type_q == TY_MRD || type_q == TY_MWR) begin
      auto_n = 8'(MEM_WAIT);
    end else if (type_q == TY_IORD || type_q == TY_IOWR) begin
      auto_n = 8'(IO_WAIT);
    end else begin
      auto_n = 8'd0;
    end

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (auto_n != 8'd0) begin
          state_d = S_TW;
          wcnt_d  = auto_n - 8'd1;
        end else if (!WAIT_L) begin
          state_d = S_TW;
        end else begin
          state_d = S_T3;
          if (is_read) rdata_d = data_in;
        end
      end
      S_TW: begin
        // Automatic waits run out first; only the last TW looks at WAIT_L.
        if (wcnt_q != 8'd0) begin
          wcnt_d = wcnt_q - 8'd1;
        end else if (WAIT_L) begin
          state_d = S_T3;
          if (is_read) rdata_d = data_in;
        end
      end
      S_T3:   state_d = (type_q == TY_M1) ? S_T4 : S_IDLE;
      S_T4: begin
        state_d = S_IDLE;
        r_d     = r_q + 7'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (req_valid && req_ready) begin
      if (req_type <= TY_IOWR) begin
        state_d = S_T1;
        type_d  = req_type;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Pin values for the state being entered, registered on the same edge.
  always_comb begin
    m1_d        = 1'b1;
    mreq_d      = 1'b1;
    iorq_d      = 1'b1;
    rd_d        = 1'b1;
    wr_d        = 1'b1;
    rfsh_d      = 1'b1;
    data_oe_d   = 1'b0;
    addr_oe_d   = (state_d != S_IDLE);
    addr_out_d  = addr_out;
    data_out_d  = data_out;
    rsp_valid_d = (state_d == S_T4) || (state_d == S_T3 && type_d != TY_M1);
    in_t12w     = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_TW);
    in_acc      = in_t12w || (state_d == S_T3);
    in_t23      = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);

    if (state_d != S_IDLE) addr_out_d = addr_d;

    if (state_d != S_IDLE) begin
      case (type_d)
        TY_M1: begin
          if (in_t12w) begin
            m1_d   = 1'b0;
            mreq_d = 1'b0;
            rd_d   = 1'b0;
          end else begin
            addr_out_d = {rfsh_hi, 1'b0, r_d};
            if (REFRESH_EN != 0) begin
              rfsh_d = 1'b0;
              mreq_d = (state_d != S_T3);
            end
          end
        end
        TY_MRD: begin
          if (in_acc) begin
            mreq_d = 1'b0;
            rd_d   = 1'b0;
          end
        end
        TY_MWR: begin
          if (in_acc) begin
            mreq_d     = 1'b0;
            data_oe_d  = 1'b1;
            data_out_d = wdata_d;
          end
          if (in_t23) wr_d = 1'b0;
        end
        TY_IORD: begin
          if (in_t23) begin
            iorq_d = 1'b0;
            rd_d   = 1'b0;
          end
        end
        TY_IOWR: begin
          if (in_t23) begin
            iorq_d = 1'b0;
            wr_d   = 1'b0;
          end
          if (in_acc) begin
            data_oe_d  = 1'b1;
            data_out_d = wdata_d;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= S_IDLE;
      type_q    <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wcnt_q    <= 8'd0;
      r_q       <= 7'd0;
      rdata_q   <= '0;
      M1_L      <= 1'b1;
      MREQ_L    <= 1'b1;
      IORQ_L    <= 1'b1;
      RD_L      <= 1'b1;
      WR_L      <= 1'b1;
      RFSH_L    <= 1'b1;
      addr_oe   <= 1'b0;
      data_oe   <= 1'b0;
      addr_out  <= '0;
      data_out  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      r_q       <= r_d;
      rdata_q   <= rdata_d;
      M1_L      <= m1_d;
      MREQ_L    <= mreq_d;
      IORQ_L    <= iorq_d;
      RD_L      <= rd_d;
      WR_L      <= wr_d;
      RFSH_L    <= rfsh_d;
      addr_oe   <= addr_oe_d;
      data_oe   <= data_oe_d;
      addr_out  <= addr_out_d;
      data_out  <= data_out_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  assign rsp_rdata   = rdata_q;
  assign dbg_state_o = state_q;
  assign dbg_r_o     = r_q;

endmodule

// File: tb/tb_z80_bus_cycle_unit.sv
// Directed bench for z80_bus_cycle_unit: per-access strobe masks (bit k = strobe low
// in cycle k of the access) compared against hand-derived values.
module tb_z80_bus_cycle_unit;

  logic        clk;
  logic        rst_L;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  rfsh_hi;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        WAIT_L;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;
  logic [2:0]  dbg_state;
  logic [6:0]  dbg_r;

  z80_bus_cycle_unit #(
    .ADDR_W(16), .DATA_W(8), .MEM_WAIT(0), .IO_WAIT(1), .REFRESH_EN(1)
  ) dut (
    .clk(clk), .rst_L(rst_L),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .rfsh_hi(rfsh_hi),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .addr_out(addr_out), .addr_oe(addr_oe), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .WAIT_L(WAIT_L),
    .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .RFSH_L(RFSH_L), .dbg_state_o(dbg_state), .dbg_r_o(dbg_r)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  logic [15:0] m1_m, mreq_m, iorq_m, rd_m, wr_m, rfsh_m, doe_m, rsp_m;
  logic [15:0] addr_c1, addr_c3, addr_c4;
  logic [7:0]  dout_c1, rdata_c3, rdata_c6;
  int          len_g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masks();
    m1_m = '0; mreq_m = '0; iorq_m = '0; rd_m = '0;
    wr_m = '0; rfsh_m = '0; doe_m = '0; rsp_m = '0;
  endtask

  task automatic record(input int k);
    m1_m[k]   = !M1_L;
    mreq_m[k] = !MREQ_L;
    iorq_m[k] = !IORQ_L;
    rd_m[k]   = !RD_L;
    wr_m[k]   = !WR_L;
    rfsh_m[k] = !RFSH_L;
    doe_m[k]  = data_oe;
    rsp_m[k]  = rsp_valid;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, addr_oe, data_oe, rsp_valid},
          9'b111111_000);
  endtask

  // driver: one request, then follow the access until the FSM is back in IDLE
  task automatic do_access(input logic [2:0] ty, input logic [15:0] a,
                           input logic [7:0] wd, input int nwait);
    int k;
    int guard;
    clear_masks();
    req_valid = 1'b1; req_type = ty; req_addr = a; req_wdata = wd; WAIT_L = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard == 20) check("ready_timeout", 0, 1);
    tick();
    req_valid = 1'b0; req_type = 3'd7; req_addr = 16'hFFFF; req_wdata = 8'hFF;
    k = 1;
    while (dbg_state != 3'd0 && k < 16) begin
      WAIT_L = (k >= 2 && k < 2 + nwait) ? 1'b0 : 1'b1;
      record(k);
      if (k == 1) begin addr_c1 = addr_out; dout_c1 = data_out; end
      if (k == 3) addr_c3 = addr_out;
      if (rsp_valid && (ty == 3'd0 || ty == 3'd1 || ty == 3'd3)) begin
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else check("sb_rdata", rsp_rdata, exp_q.pop_front());
      end
      tick();
      k++;
    end
    len_g = k - 1;
    WAIT_L = 1'b1;
    check_idle("idle_after");
  endtask

  initial begin
    int k;
    rst_L = 1'b0; req_valid = 1'b0; req_type = 3'd0; req_addr = '0; req_wdata = '0;
    rfsh_hi = 8'h12; data_in = 8'h00; WAIT_L = 1'b1;
    repeat (3) tick();
    check_idle("rst_strobes");
    check("rst_rdata", rsp_rdata, 0);
    check("rst_addr", addr_out, 0);
    check("rst_dout", data_out, 0);
    check("rst_r", dbg_r, 0);
    check("rst_ready", req_ready, 1);
    @(negedge clk);
    rst_L = 1'b1;
    tick();

    // M1 fetch with refresh
    data_in = 8'h3E;
    exp_q.push_back(8'h3E);
    do_access(3'd0, 16'h0000, 8'h00, 0);
    check("m1_len", len_g, 4);
    check("m1_m1", m1_m, 16'h0006);
    check("m1_mreq", mreq_m, 16'h000E);
    check("m1_rd", rd_m, 16'h0006);
    check("m1_rfsh", rfsh_m, 16'h0018);
    check("m1_rsp", rsp_m, 16'h0010);
    check("m1_addr", addr_c1, 16'h0000);
    check("m1_rfaddr", addr_c3, 16'h1200);
    check("m1_rdata", rsp_rdata, 8'h3E);
    check("m1_r", dbg_r, 1);

    // memory write stretched by two external waits
    do_access(3'd2, 16'hC000, 8'hA5, 2);
    check("mwr_len", len_g, 5);
    check("mwr_mreq", mreq_m, 16'h003E);
    check("mwr_wr", wr_m, 16'h003C);
    check("mwr_rd", rd_m, 16'h0000);
    check("mwr_doe", doe_m, 16'h003E);
    check("mwr_rsp", rsp_m, 16'h0020);
    check("mwr_addr", addr_c1, 16'hC000);
    check("mwr_dout", dout_c1, 8'hA5);

    // I/O read with one automatic wait
    data_in = 8'h5A;
    exp_q.push_back(8'h5A);
    do_access(3'd3, 16'h00FE, 8'h00, 0);
    check("iord_len", len_g, 4);
    check("iord_iorq", iorq_m, 16'h001C);
    check("iord_rd", rd_m, 16'h001C);
    check("iord_mreq", mreq_m, 16'h0000);
    check("iord_rsp", rsp_m, 16'h0010);
    check("iord_rdata", rsp_rdata, 8'h5A);

    // I/O write
    do_access(3'd4, 16'h0042, 8'h3C, 0);
    check("iowr_len", len_g, 4);
    check("iowr_wr", wr_m, 16'h001C);
    check("iowr_iorq", iorq_m, 16'h001C);
    check("iowr_doe", doe_m, 16'h001E);
    check("iowr_dout", dout_c1, 8'h3C);

    // single memory read
    data_in = 8'h77;
    exp_q.push_back(8'h77);
    do_access(3'd1, 16'h4321, 8'h00, 0);
    check("mrd_len", len_g, 3);
    check("mrd_mreq", mreq_m, 16'h000E);
    check("mrd_rd", rd_m, 16'h000E);
    check("mrd_rsp", rsp_m, 16'h0008);
    check("mrd_addr", addr_c1, 16'h4321);

    // back-to-back memory reads with req_valid held
    clear_masks();
    data_in = 8'h11;
    req_valid = 1'b1; req_type = 3'd1; req_addr = 16'h1000;
    tick();
    k = 1;
    while (dbg_state != 3'd0 && k < 16) begin
      record(k);
      if (k == 2) req_addr = 16'h2000;
      if (k == 3) begin rdata_c3 = rsp_rdata; data_in = 8'h22; end
      if (k == 4) begin addr_c4 = addr_out; req_valid = 1'b0; end
      if (k == 6) rdata_c6 = rsp_rdata;
      tick();
      k++;
    end
    check("b2b_len", k - 1, 6);
    check("b2b_rsp", rsp_m, 16'h0048);
    check("b2b_mreq", mreq_m, 16'h007E);
    check("b2b_addr2", addr_c4, 16'h2000);
    check("b2b_rdata1", rdata_c3, 8'h11);
    check("b2b_rdata2", rdata_c6, 8'h22);

    // R counter wrap: 127 more M1 cycles brings R from 1 back to 0
    data_in = 8'h00;
    for (int i = 0; i < 127; i++) begin
      exp_q.push_back(8'h00);
      do_access(3'd0, 16'h0100, 8'h00, 0);
    end
    check("wrap_last_rf", addr_c3, 16'h127F);
    check("wrap_r", dbg_r, 0);
    exp_q.push_back(8'h00);
    do_access(3'd0, 16'h0100, 8'h00, 0);
    check("wrap_rf0", addr_c3, 16'h1200);
    check("wrap_r1", dbg_r, 1);

    // illegal request type is swallowed
    do_access(3'd6, 16'h5555, 8'h00, 0);
    check("ill_len", len_g, 0);
    check("ill_ready", req_ready, 1);
    check("sb_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of an I/O wait state
    req_valid = 1'b1; req_type = 3'd3; req_addr = 16'h00FE;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("rst_mid_tw", dbg_state, 3);
    #2;
    rst_L = 1'b0;
    #1;
    check_idle("rst_mid_strobes");
    check("rst_mid_state", dbg_state, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_L = 1'b1;
    tick();
    check("rst_post_ready", req_ready, 1);
    check("rst_post_r", dbg_r, 0);
    check("rst_post_rdata", rsp_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
